alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the lab combinational ALU.
- Two W-bit operands, eight functions selected by a 3-bit code, 2W-bit registered result.
- Internal 2W-bit accumulator that can feed operand B, enabling chained operations.
- Multiply is a multi-cycle shift-add; all other functions complete in one cycle. Sits between switch/key input logic and LEDR/seven-segment display logic.

Parameters:
- W, 4, operand width in bits (W >= 2); result and accumulator are 2W bits.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- func  input  3  function code, captured with start.
- a  input  W  operand A, captured with start.
- b  input  W  operand B, captured with start.
- use_acc  input  1  captured with start; 1 = operand B taken from acc[W-1:0] instead of b.
- acc_we  input  1  captured with start; 1 = copy result into accumulator on completion.
- acc_clr  input  1  synchronous accumulator clear.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when result updates.
- result  output  2W  last completed result.
- acc  output  2W  accumulator value.
- flags  output  4  {zero, carry, negative, overflow}; see Optional Feature.

Behaviour:
- Reset: asynchronous on resetn=0. busy=0, done=0, result=0, acc=0, flags=0, FSM to IDLE. A reset during a multiply aborts it, with no done pulse.
- FSM states:
  - IDLE: start=1 and func!=7 → compute; result registered at the same edge; done=1 next cycle; stay IDLE.
  - IDLE: start=1 and func=7 → MUL; latch operands; busy=1.
  - MUL: one shift-add step per edge for W edges. On the W-th edge, result=product, done=1, busy=0, return to IDLE.
  - Multiply latency is W edges after the start edge.
- start while busy=1 is ignored and not queued. start held high in IDLE issues a new operation every cycle; a multiply re-issues on the edge after it completes.
- Functions, with B = operand after use_acc mux and results zero-extended to 2W unless stated:
  - 0: A+B, carry-out in bit W.
  - 1: A−B, two's complement, sign-extended to 2W.
  - 2: {A|B, A^B}, OR in the upper W bits.
  - 3: 1 if any bit of A or B is set, else 0.
  - 4: {A, B}.
  - 5: B << A (logical, B zero-extended to 2W); shift amount >= 2W gives 0.
  - 6: B >> A (logical); shift amount >= 2W gives 0.
  - 7: A*B unsigned, full 2W product.
- Accumulator:
  - On a done cycle with latched acc_we=1, acc takes the new result; it updates at the same edge as result.
  - acc_clr=1 clears acc at the next edge.
  - If acc_clr and an acc_we completion coincide, the clear wins.
  - acc_clr during MUL does not affect the multiply's latched operands.
- done is never high for more than one consecutive cycle per operation. Back-to-back single-cycle operations give consecutive done pulses.

Optional Feature:
- Macro ALU_SEQ_FLAGS_EN.
- Defined: flags are registered alongside result on every completion:
  - zero = (result==0).
  - carry = bit W of the sum for func 0, borrow for func 1, 0 otherwise.
  - negative = result[2W-1].
  - overflow = signed W-bit overflow for func 0/1, 0 otherwise.
  - Reset value 0.
- Undefined: flags is tied to 4'b0000 and no flag logic is built.

Test Plan (W=4):
- Reset mid-multiply: start func=7 a=15 b=15, pull resetn low after 2 edges → busy=0, result=0, no done pulse. After release, idle with acc=0.
- Add with carry: func=0 a=9 b=8 → done next cycle, result=8'h11, busy never high. With ALU_SEQ_FLAGS_EN, flags carry=1 and overflow=1.
- Subtract: func=1 a=3 b=5 → result=8'hFE. With the flag macro, negative=1.
- Multiply timing: func=7 a=15 b=15 → busy=1 for 4 cycles, done on the 4th edge after start, result=8'hE1. A second start while busy is ignored, so result stays 8'hE1.
- Accumulate chain: acc_clr, then func=0 a=2 b=3 acc_we=1 → acc=5. Then func=0 a=1 use_acc=1 acc_we=1 → acc=6. Then acc_clr together with a completing acc_we op → acc=0.
- Shifts: func=5 a=2 b=4'hF → 8'h3C. func=5 a=9 b=1 → 8'h00. func=6 a=1 b=4'hA → 8'h05. func=3 a=0 b=0 → 0; a=0 b=1 → 1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with accumulator chaining and multi-cycle shift-add multiply.
// Define ALU_SEQ_FLAGS_EN to build the {zero, carry, negative, overflow} flag register.
`timescale 1ns/1ps
module alu_seq #(
    parameter int W = 4
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      func,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic            use_acc,
    input  logic            acc_we,
    input  logic            acc_clr,
    output logic            busy,
    output logic            done,
    output logic [2*W-1:0]  result,
    output logic [2*W-1:0]  acc,
    output logic [3:0]      flags
);
    localparam int RW = 2 * W;
    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_nxt;

    logic [W-1:0]  bop;
    logic [W:0]    sum;
    logic [W-1:0]  dif;
    logic [RW-1:0] bz, alu_res, psum;
    logic [RW-1:0] mcand, prod;
    logic [W-1:0]  mplier;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic          fire_alu, fire_mul, mul_last;
    logic          shift_oor;

    assign bop       = use_acc ? acc[W-1:0] : b;
    assign sum       = {1'b0, a} + {1'b0, bop};
    assign dif       = a - bop;
    assign bz        = {{W{1'b0}}, bop};
    assign shift_oor = 32'(a) >= 32'(RW);
    assign psum      = prod + (mplier[0] ? mcand : '0);

    always_comb begin
        alu_res = '0;
        case (func)
            3'd0:    alu_res = {{(RW-W-1){1'b0}}, sum};
            3'd1:    alu_res = {{W{dif[W-1]}}, dif};
            3'd2:    alu_res = {a | bop, a ^ bop};
            3'd3:    alu_res = {{(RW-1){1'b0}}, (|a) | (|bop)};
            3'd4:    alu_res = {a, bop};
            3'd5:    alu_res = shift_oor ? '0 : bz << a;
            3'd6:    alu_res = shift_oor ? '0 : bz >> a;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && func == 3'd7) state_nxt = MUL;
            MUL:     if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == MUL);
        fire_alu = (state == IDLE) && start && (func != 3'd7);
        fire_mul = (state == IDLE) && start && (func == 3'd7);
        mul_last = (state == MUL) && (cnt == '0);
    end

    // cnt counts the remaining steps; the last step writes psum straight to result
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            result <= '0;
            done   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            we_q   <= 1'b0;
        end else begin
            done <= fire_alu | mul_last;
            if (fire_alu)      result <= alu_res;
            else if (mul_last) result <= psum;

            if (fire_mul) begin
                mcand  <= {{W{1'b0}}, a};
                mplier <= bop;
                prod   <= '0;
                cnt    <= CW'(W - 1);
                we_q   <= acc_we;
            end else if (busy) begin
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                prod   <= psum;
                cnt    <= cnt - CW'(1);
            end

            if (acc_clr)                  acc <= '0;
            else if (fire_alu && acc_we)  acc <= alu_res;
            else if (mul_last && we_q)    acc <= psum;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic c_f, v_f;

    always_comb begin
        c_f = 1'b0;
        v_f = 1'b0;
        if (func == 3'd0) begin
            c_f = sum[W];
            v_f = (a[W-1] == bop[W-1]) && (sum[W-1] != a[W-1]);
        end else if (func == 3'd1) begin
            c_f = (a < bop);
            v_f = (a[W-1] != bop[W-1]) && (dif[W-1] != a[W-1]);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)       flags <= 4'b0000;
        else if (fire_alu) flags <= {alu_res == '0, c_f, alu_res[RW-1], v_f};
        else if (mul_last) flags <= {psum == '0, 1'b0, psum[RW-1], 1'b0};
    end
`else
    assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq;
    localparam int W = 4;

    logic           clock = 1'b0;
    logic           resetn = 1'b0;
    logic           start = 1'b0;
    logic [2:0]     func = '0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           use_acc = 1'b0;
    logic           acc_we = 1'b0;
    logic           acc_clr = 1'b0;
    logic           busy, done;
    logic [2*W-1:0] result, acc;
    logic [3:0]     flags;

    int     total = 0;
    int     bad = 0;
    longint m_acc = 0;
    longint m_res = 0;

    alu_seq #(.W(W)) dut (
        .clock(clock), .resetn(resetn), .start(start), .func(func),
        .a(a), .b(b), .use_acc(use_acc), .acc_we(acc_we), .acc_clr(acc_clr),
        .busy(busy), .done(done), .result(result), .acc(acc), .flags(flags)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic longint model(input int f, input longint x, input longint y);
        longint full = (longint'(1) << (2*W));
        longint d;
        case (f)
            0: return x + y;
            1: begin
                d = (x - y) & ((longint'(1) << W) - 1);
                return (d >= (longint'(1) << (W-1))) ? d + full - (longint'(1) << W) : d;
            end
            2: return ((x | y) << W) | (x ^ y);
            3: return (x != 0 || y != 0) ? 1 : 0;
            4: return (x << W) | y;
            5: return (x >= 2*W) ? 0 : (y << x) & (full - 1);
            6: return (x >= 2*W) ? 0 : y >> x;
            default: return x * y;
        endcase
    endfunction

    function automatic logic [3:0] xflags(input int f, input longint x, input longint y, input longint r);
        longint sx, sy, s;
        longint hi = (longint'(1) << (W-1));
        bit c, v, z, n;
        sx = (x >= hi) ? x - 2*hi : x;
        sy = (y >= hi) ? y - 2*hi : y;
        c = 0; v = 0;
        if (f == 0) begin
            c = (x + y) >= 2*hi;
            s = sx + sy;
            v = (s > hi - 1) || (s < -hi);
        end else if (f == 1) begin
            c = x < y;
            s = sx - sy;
            v = (s > hi - 1) || (s < -hi);
        end
        z = (r == 0);
        n = ((r >> (2*W-1)) & 1) != 0;
        return {z, c, n, v};
    endfunction

    task automatic issue(input int f, input int x, input int y, input bit ua,
                         input bit we, input bit clr, input bit mid_clr);
        longint bv, er;
        int n;
        bv = ua ? (m_acc & ((longint'(1) << W) - 1)) : longint'(y);
        er = model(f, x, bv);
        @(negedge clock);
        chk("done_idle", done, 0);
        chk("res_hold", result, m_res);
        start = 1; func = 3'(f); a = W'(x); b = W'(y);
        use_acc = ua; acc_we = we; acc_clr = clr;
        @(negedge clock);
        start = 0; acc_clr = 0;
        if (clr) m_acc = 0;
        if (f != 7) begin
            chk("busy_alu", busy, 0);
            chk("done_alu", done, 1);
        end else begin
            n = 0;
            // a competing request held during the multiply must be dropped
            start = 1; func = 3'd0; a = 1; b = 1; use_acc = 0; acc_we = 1;
            while (!done && n < 4*W + 4) begin
                chk("busy_mul", busy, 1);
                acc_clr = mid_clr && (n == 1);
                @(negedge clock);
                n++;
            end
            start = 0; acc_clr = 0; acc_we = 0;
            chk("mul_lat", n, W);
            chk("busy_end", busy, 0);
            if (mid_clr) m_acc = 0;
        end
        if (we && (f == 7 || !clr)) m_acc = er;
        m_res = er;
        chk("result", result, er);
        chk("acc", acc, m_acc);
`ifdef ALU_SEQ_FLAGS_EN
        chk("flags", flags, xflags(f, x, bv, er));
`else
        chk("flags", flags, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_acc", acc, 0);
        chk("rst_flags", flags, 0);
        @(negedge clock);
        resetn = 1;

        issue(0, 9, 8, 0, 1, 0, 0);
        issue(1, 3, 5, 0, 0, 0, 0);

        // abort a multiply with reset
        @(negedge clock);
        start = 1; func = 3'd7; a = W'(15); b = W'(15); use_acc = 0; acc_we = 1;
        @(negedge clock); start = 0;
        @(negedge clock);
        @(negedge clock);
        resetn = 0;
        #1;
        chk("rmul_busy", busy, 0);
        chk("rmul_done", done, 0);
        chk("rmul_result", result, 0);
        chk("rmul_acc", acc, 0);
        @(negedge clock);
        chk("rmul_done_hold", done, 0);
        resetn = 1; acc_we = 0;
        @(negedge clock);
        chk("rmul_idle_busy", busy, 0);
        chk("rmul_idle_done", done, 0);
        chk("rmul_idle_acc", acc, 0);
        m_acc = 0; m_res = 0;

        issue(7, 15, 15, 0, 0, 0, 0);

        @(negedge clock);
        acc_clr = 1;
        @(negedge clock);
        acc_clr = 0; m_acc = 0;
        chk("clr_acc", acc, 0);

        issue(0, 2, 3, 0, 1, 0, 0);
        issue(0, 1, 0, 1, 1, 0, 0);
        issue(0, 4, 4, 0, 1, 1, 0);

        issue(5, 2, 15, 0, 0, 0, 0);
        issue(5, 9, 1, 0, 0, 0, 0);
        issue(6, 1, 10, 0, 0, 0, 0);
        issue(3, 0, 0, 0, 0, 0, 0);
        issue(3, 0, 1, 0, 0, 0, 0);

        // clear mid-multiply must not disturb the latched accumulator operand
        issue(4, 3, 5, 0, 1, 0, 0);
        issue(7, 3, 0, 1, 0, 0, 1);
        issue(2, 12, 10, 0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            issue(int'($urandom_range(0, 7)), int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
                  1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
